// File: rtl/enemy_path_walker.sv
// Walks the enemy path ROM one waypoint per frame tick and retires the enemy on path end or kill.
// Optional ENEMY_PATH_LOOP_EN: on the last waypoint, restart at the latched start address.
module enemy_path_walker #(
  parameter int ADRESSWIDTH = 10,
  parameter int XWIDTH      = 11,
  parameter int YWIDTH      = 10,
  parameter int MAX_STEPS   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spawn,
  input  logic [ADRESSWIDTH-1:0]        adr_start,
  input  logic                          frame_tick,
  input  logic                          kill,
  output logic [ADRESSWIDTH-1:0]        rom_adr,
  input  logic [XWIDTH+YWIDTH:0]        rom_data,
  output logic [XWIDTH-1:0]             enemy_x,
  output logic [YWIDTH-1:0]             enemy_y,
  output logic                          enemy_valid,
  output logic                          busy,
  output logic [7:0]                    step_cnt,
  output logic                          path_done,
  output logic                          flip_next
);
  localparam logic [7:0] MAX_W = 8'(MAX_STEPS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADRESSWIDTH-1:0]   rom_adr_q, rom_adr_d;
  logic [XWIDTH-1:0]        x_q, x_d;
  logic [YWIDTH-1:0]        y_q, y_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic [7:0]               step_q, step_d;
  logic                     done_q, done_d;
  logic                     flip_q, flip_d;
  logic                     busy_q, busy_d;
`ifdef ENEMY_PATH_LOOP_EN
  logic [ADRESSWIDTH-1:0]   start_q, start_d;
`endif

  always_comb begin
    state_d   = state_q;
    rom_adr_d = rom_adr_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = valid_q;
    last_d    = last_q;
    step_d    = step_q;
    done_d    = 1'b0;
    flip_d    = 1'b0;
`ifdef ENEMY_PATH_LOOP_EN
    start_d   = start_q;
`endif
    case (state_q)
      S_IDLE: if (spawn) begin
        rom_adr_d = adr_start;
        step_d    = 8'd0;
        state_d   = S_FETCH;
`ifdef ENEMY_PATH_LOOP_EN
        start_d   = adr_start;
`endif
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        x_d     = rom_data[XWIDTH+YWIDTH-1:YWIDTH];
        y_d     = rom_data[YWIDTH-1:0];
        last_d  = rom_data[XWIDTH+YWIDTH];
        valid_d = 1'b1;
        step_d  = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
        state_d = S_HOLD;
      end
      S_HOLD: if (frame_tick) begin
        if (step_q == MAX_W) begin
          state_d = S_DONE;
`ifndef ENEMY_PATH_LOOP_EN
          done_d  = 1'b1;
          flip_d  = 1'b1;
`endif
        end else if (last_q) begin
`ifdef ENEMY_PATH_LOOP_EN
          rom_adr_d = start_q;
          step_d    = 8'd0;
          state_d   = S_FETCH;
`else
          state_d   = S_DONE;
          done_d    = 1'b1;
          flip_d    = 1'b1;
`endif
        end else begin
          rom_adr_d = rom_adr_q + ADRESSWIDTH'(1);
          state_d   = S_FETCH;
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Kill overrides everything in the active states, including a same-cycle tick or capture.
    if (kill && (state_q == S_FETCH || state_q == S_WAIT || state_q == S_HOLD)) begin
      state_d   = S_IDLE;
      rom_adr_d = rom_adr_q;
      x_d       = x_q;
      y_d       = y_q;
      last_d    = last_q;
      step_d    = step_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      flip_d    = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rom_adr_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      step_q    <= 8'd0;
      done_q    <= 1'b0;
      flip_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ENEMY_PATH_LOOP_EN
      start_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rom_adr_q <= rom_adr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      step_q    <= step_d;
      done_q    <= done_d;
      flip_q    <= flip_d;
      busy_q    <= busy_d;
`ifdef ENEMY_PATH_LOOP_EN
      start_q   <= start_d;
`endif
    end
  end

  assign rom_adr     = rom_adr_q;
  assign enemy_x     = x_q;
  assign enemy_y     = y_q;
  assign enemy_valid = valid_q;
  assign busy        = busy_q;
  assign step_cnt    = step_q;
  assign path_done   = done_q;
  assign flip_next   = flip_q;
endmodule

// File: tb/tb_enemy_path_walker.sv
// Randomized bench for enemy_path_walker: expected waypoints come from walking a ROM image array.
module tb_enemy_path_walker;
  localparam int AW = 10, XW = 11, YW = 10, MS = 4;

  logic          clk = 1'b0;
  logic          rst, spawn, frame_tick, kill;
  logic [AW-1:0] adr_start, rom_adr;
  logic [XW+YW:0] rom_data;
  logic [XW-1:0] enemy_x;
  logic [YW-1:0] enemy_y;
  logic          enemy_valid, busy, path_done, flip_next;
  logic [7:0]    step_cnt;

  logic [XW+YW:0] mem [0:1023];
  int errors = 0, checks = 0;

  enemy_path_walker #(.ADRESSWIDTH(AW), .XWIDTH(XW), .YWIDTH(YW), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .spawn(spawn), .adr_start(adr_start), .frame_tick(frame_tick),
    .kill(kill), .rom_adr(rom_adr), .rom_data(rom_data), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_valid(enemy_valid), .busy(busy), .step_cnt(step_cnt), .path_done(path_done),
    .flip_next(flip_next)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_adr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_adr"}, rom_adr, 0);   chk({tag, "_x"}, enemy_x, 0);
    chk({tag, "_y"}, enemy_y, 0);     chk({tag, "_valid"}, enemy_valid, 0);
    chk({tag, "_busy"}, busy, 0);     chk({tag, "_step"}, step_cnt, 0);
    chk({tag, "_done"}, path_done, 0); chk({tag, "_flip"}, flip_next, 0);
  endtask

  function automatic logic [XW+YW:0] wp(input bit last, input int x, input int y);
    return {last, XW'(x), YW'(y)};
  endfunction

  // mode 0: run to completion, 1: kill in HOLD of waypoint abort_at, 2: reset there.
  task automatic walk(input int start, input int mode, input int abort_at, input int gap,
                      input bit hold_sp);
    int adr[$];
    logic [XW+YW:0] w[$];
    int a, n, ab;
    a = start;
    for (int k = 0; k < MS; k++) begin
      adr.push_back(a); w.push_back(mem[a]);
      if (mem[a][XW+YW]) break;
      a = (a + 1) % 1024;
    end
    n  = w.size();
    ab = (abort_at >= n) ? n - 1 : abort_at;

    adr_start = AW'(start); spawn = 1'b1; kill = 1'($urandom_range(0, 1));
    step();
    spawn = 1'b0; kill = 1'b0;
    chk("spawn_adr", rom_adr, start); chk("spawn_busy", busy, 1);
    chk("spawn_flip", flip_next, 0);  chk("spawn_valid", enemy_valid, 0);
    step(); step();
    for (int i = 0; i < n; i++) begin
      chk("wp_x", enemy_x, w[i][XW+YW-1:YW]); chk("wp_y", enemy_y, w[i][YW-1:0]);
      chk("wp_valid", enemy_valid, 1);       chk("wp_step", step_cnt, i + 1);
      chk("wp_adr", rom_adr, adr[i]);
      if (hold_sp) begin
        spawn = 1'b1; repeat (5) step(); spawn = 1'b0;
        chk("spawn_ign_adr", rom_adr, adr[i]); chk("spawn_ign_step", step_cnt, i + 1);
      end
      repeat (gap) step();
      if (mode != 0 && i == ab) begin
        if (mode == 1) begin
          kill = 1'b1; frame_tick = 1'($urandom_range(0, 1));
          step();
          kill = 1'b0; frame_tick = 1'b0;
          chk("kill_flip", flip_next, 1); chk("kill_valid", enemy_valid, 0);
          chk("kill_done", path_done, 0); chk("kill_busy", busy, 0);
          chk("kill_adr", rom_adr, adr[i]);
        end else begin
          rst = 1'b0; step(); rst = 1'b1;
          chk_reset_vals("midrst");
        end
        return;
      end
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      if (i == n - 1) begin
        chk("end_done", path_done, 1); chk("end_flip", flip_next, 1);
        chk("end_valid_t1", enemy_valid, 1);
        kill = 1'($urandom_range(0, 1));
        step();
        kill = 1'b0;
        chk("end_done_t2", path_done, 0); chk("end_flip_t2", flip_next, 0);
        chk("end_valid_t2", enemy_valid, 0); chk("end_busy_t2", busy, 0);
        chk("end_step", step_cnt, n); chk("end_x_keep", enemy_x, w[i][XW+YW-1:YW]);
        return;
      end
      chk("next_adr", rom_adr, adr[i+1]);
      chk("noglitch_x", enemy_x, w[i][XW+YW-1:YW]); chk("noglitch_y", enemy_y, w[i][YW-1:0]);
      frame_tick = 1'($urandom_range(0, 1)); step();
      frame_tick = 1'($urandom_range(0, 1)); step();
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = XW+YW+1'($urandom);
    rst = 1'b0; spawn = 1'b0; frame_tick = 1'b0; kill = 1'b0; adr_start = '0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b1;
    step();
    kill = 1'b1; step(); kill = 1'b0;
    chk("idle_kill_flip", flip_next, 0); chk("idle_kill_busy", busy, 0);

    mem[10'h040] = wp(0, 100, 50); mem[10'h041] = wp(0, 110, 60); mem[10'h042] = wp(1, 120, 70);
    walk(10'h040, 0, 0, 19, 1'b0);
    walk(10'h040, 1, 1, 1, 1'b0);
    mem[10'h3FF] = wp(0, 7, 8); mem[10'h000] = wp(1, 9, 10);
    walk(10'h3FF, 0, 0, 2, 1'b1);
    for (int j = 0; j < 6; j++) mem[10'h100 + j] = wp(0, 200 + j, 300 + j);
    walk(10'h100, 0, 0, 3, 1'b0);
    walk(10'h100, 2, 1, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int st, len, mode;
      bit nolast;
      st     = (t % 8 == 0) ? 1023 : int'($urandom_range(0, 1023));
      len    = $urandom_range(1, 6);
      nolast = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < len; j++)
        mem[(st + j) % 1024] = wp((j == len - 1) && !nolast, $urandom_range(0, 2047),
                                  $urandom_range(0, 1023));
      mode = ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      walk(st, mode, $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/enemy_path_walker.md
# enemy_path_walker

Downstream consumer of the enemy start-address selector. On a spawn request it latches the selected start address and walks the enemy path ROM one waypoint per frame tick, presenting the current enemy position to the renderer and collision logic. When the enemy finishes its path or is killed, it retires the enemy and pulses `flip_next`, which drives the selector's `flip` input so the next spawn uses the next start address.

## Interface
- `ADRESSWIDTH`, 10: path ROM address width; matches the selector output.
- `XWIDTH`, 11: enemy x coordinate width.
- `YWIDTH`, 10: enemy y coordinate width.
- `MAX_STEPS`, 255: guard limit on waypoints per path. Range 1 to 255.
- ROM word layout: `{last, x, y}`, `1+XWIDTH+YWIDTH` bits; MSB `last` marks the final waypoint.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-low reset; sampled on `posedge clk`.
- `spawn`  input  1  spawn request; level sampled each cycle.
- `adr_start`  input  ADRESSWIDTH  start address, from the selector's `adr_enemy_random`.
- `frame_tick`  input  1  one-cycle pulse per frame; advances the path.
- `kill`  input  1  enemy destroyed; aborts the walk.
- `rom_adr`  output  ADRESSWIDTH  path ROM address, registered.
- `rom_data`  input  1+XWIDTH+YWIDTH  ROM read data; synchronous ROM, 1-cycle latency.
- `enemy_x`  output  XWIDTH  current enemy x.
- `enemy_y`  output  YWIDTH  current enemy y.
- `enemy_valid`  output  1  enemy alive and position valid.
- `busy`  output  1  high in every state except IDLE.
- `step_cnt`  output  8  waypoints loaded since spawn.
- `path_done`  output  1  one-cycle pulse on normal path completion.
- `flip_next`  output  1  one-cycle pulse on any retirement; drives the selector's `flip`.

## Operation
- Reset values: `rom_adr`=0, `enemy_x`=0, `enemy_y`=0, `enemy_valid`=0, `busy`=0, `step_cnt`=0, `path_done`=0, `flip_next`=0, state IDLE.
- Reset asserted mid-walk returns to IDLE with the reset values above. No `flip_next` pulse is generated.
- State machine:
  - IDLE: `spawn`=1 sets `rom_adr`←`adr_start` and `step_cnt`←0, then goes to FETCH.
  - FETCH: the address is on the ROM. Goes to WAIT.
  - WAIT: `rom_data` is valid this cycle. Capture x, y and `last`; set `enemy_valid`←1; `step_cnt`+1 (saturating at 255). Goes to HOLD.
  - HOLD, on `frame_tick`:
    - If `last`=1, or `step_cnt`==`MAX_STEPS`, go to DONE.
    - Otherwise set `rom_adr`←`rom_adr`+1 and go to FETCH.
  - DONE: `path_done`=1, `flip_next`=1, `enemy_valid`←0. Goes to IDLE.
- `rom_adr` increments modulo 2^ADRESSWIDTH; wrapping from all-ones to 0 is legal.
- `frame_tick` arriving in FETCH, WAIT or DONE is dropped, not queued.
- `spawn` outside IDLE is ignored.
- `kill` in FETCH, WAIT or HOLD: next cycle enters IDLE with `enemy_valid`=0 and `flip_next`=1 for one cycle; `path_done` stays 0.
- `kill` in IDLE or DONE is ignored.
- `kill` and `frame_tick` in the same cycle: `kill` wins.
- `kill` and `spawn` in the same cycle while in IDLE: `spawn` is accepted.
- `enemy_x` and `enemy_y` hold the previous waypoint during refetch, so there is no glitch to 0 between waypoints. They keep their last value after retirement; consumers qualify them with `enemy_valid`.

## Timing
- `spawn` sampled at cycle N: `rom_adr`=`adr_start` at N+1, and `enemy_valid`=1 with the first waypoint at N+3.
- `frame_tick` in HOLD at cycle T: the new waypoint is visible at T+3.
- Last-waypoint `frame_tick` at T: `path_done` and `flip_next` high at T+1, `enemy_valid` low from T+2, state IDLE at T+2. Minimum respawn: `spawn` accepted at T+2.
- `kill` at K: `flip_next` high and `enemy_valid` low at K+1. A new `spawn` is accepted from K+1.
- Every output is registered; there is no combinational input-to-output path.

## Configuration
- `ENEMY_PATH_LOOP_EN` defined: when `last`=1 and `frame_tick` arrives in HOLD, the block reloads `rom_adr`←the latched start address, sets `step_cnt`←0 and goes to FETCH. The enemy patrols until killed.
  - `path_done` never pulses; `flip_next` pulses only on `kill`.
  - The `MAX_STEPS` guard still forces DONE.
- `ENEMY_PATH_LOOP_EN` not defined: `last`=1 ends the path through DONE, as in Operation.

## Test plan
- Reset, then a 3-waypoint path at address 0x040: (100,50), (110,60), (120,70, last). Pulse `spawn`, then `frame_tick` every 20 cycles. Expect positions at +3 cycles per tick, `step_cnt` 1→3, one `path_done`+`flip_next` pulse, then IDLE.
- `kill` at cycle 2 of HOLD on the second waypoint. Expect `flip_next`=1 and `enemy_valid`=0 next cycle, `path_done` never asserted. Respawn accepted the following cycle.
- `kill` and `frame_tick` in the same cycle: no address increment, retirement as in the kill case. Also `frame_tick` during WAIT: dropped, `rom_adr` unchanged.
- Start address 0x3FF with a 2-waypoint path: second fetch at 0x000. `spawn` held high for 5 cycles during the walk: ignored.
- Path with no `last` flag and `MAX_STEPS`=4: DONE after the 4th tick, `step_cnt`=4. `rst`=0 mid-HOLD: all outputs return to reset values, with no `flip_next`.
- With `ENEMY_PATH_LOOP_EN`: a 2-waypoint path loops back to the start address 3 times without `path_done`; `kill` ends it with `flip_next`.
